// File: rtl/axis_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_packet_arbiter
//
// Packet-granular round-robin arbiter that merges two AXI4-Stream sinks
// (s00, s01) onto one AXI4-Stream master (m00). A grant is taken on the first
// beat of a packet and released only when that packet's end beat is accepted,
// so packets from the two sources are never interleaved. When both sources
// request at the same time, the port that was not served last wins. Packets
// longer than C_MAX_BEATS are cut: tlast is forced on beat C_MAX_BEATS, the
// sticky overrun flag is raised, and the remaining beats form a new packet.
//
// Optional build macro:
//   AXIS_ARB_OUT_REG_EN  - inserts a 2-entry skid buffer between the arbiter
//                          mux and m00. All m00 outputs become registers
//                          (+1 cycle latency, full throughput) and s*_tready no
//                          longer depends combinationally on m00_axis_tready.
//                          Undefined: zero-latency combinational path.
//
// Ports:
//   axis_aclk, axis_areset      clock, asynchronous active-high reset
//   s00_axis_*, s01_axis_*      sink streams (tdata, tstrb, tlast, tvalid, tready)
//   m00_axis_*                  arbitrated master stream
//   stat_clear                  synchronous clear of pkt_cnt0/1 and overrun
//   pkt_cnt0, pkt_cnt1          wrapping count of packets forwarded per source
//   overrun                     sticky flag: a packet was truncated
// -----------------------------------------------------------------------------
module axis_rr_packet_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_MAX_BEATS        = 256,
    parameter int C_CNT_WIDTH        = 16
) (
    input  logic                            axis_aclk,
    input  logic                            axis_areset,

    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                            s00_axis_tlast,
    input  logic                            s00_axis_tvalid,
    output logic                            s00_axis_tready,

    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                            s01_axis_tlast,
    input  logic                            s01_axis_tvalid,
    output logic                            s01_axis_tready,

    output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                            m00_axis_tlast,
    output logic                            m00_axis_tvalid,
    input  logic                            m00_axis_tready,

    input  logic                            stat_clear,
    output logic [C_CNT_WIDTH-1:0]          pkt_cnt0,
    output logic [C_CNT_WIDTH-1:0]          pkt_cnt1,
    output logic                            overrun
);

    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int SW = C_AXIS_TDATA_WIDTH / 8;
    localparam int BW = $clog2(C_MAX_BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(C_MAX_BEATS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    // Sources gathered into arrays so the mux and counters index by port.
    logic [DW-1:0]    src_tdata [2];
    logic [SW-1:0]    src_tstrb [2];
    logic [1:0]       src_tlast;
    logic [1:0]       src_tvalid;

    assign src_tdata[0] = s00_axis_tdata;
    assign src_tdata[1] = s01_axis_tdata;
    assign src_tstrb[0] = s00_axis_tstrb;
    assign src_tstrb[1] = s01_axis_tstrb;
    assign src_tlast    = {s01_axis_tlast,  s00_axis_tlast};
    assign src_tvalid   = {s01_axis_tvalid, s00_axis_tvalid};

    logic [1:0]       state_reg, state_next;
    logic             last_served_reg;
    logic [BW-1:0]    beat_cnt_reg;
    logic             overrun_reg;
    logic [C_CNT_WIDTH-1:0] pkt_cnt_reg [2];

    // Arbiter-side stream (before the optional output buffer).
    logic             granted;
    logic             sel;
    logic [DW-1:0]    arb_tdata;
    logic [SW-1:0]    arb_tstrb;
    logic             arb_tlast;
    logic             arb_tvalid;
    logic             arb_ready;
    logic             force_last;
    logic             beat;
    logic             end_beat;

    assign granted    = (state_reg == ST_GRANT0) || (state_reg == ST_GRANT1);
    assign sel        = (state_reg == ST_GRANT1);
    assign arb_tdata  = granted ? src_tdata[sel] : '0;
    assign arb_tstrb  = granted ? src_tstrb[sel] : '0;
    assign arb_tvalid = granted & src_tvalid[sel];
    // Truncation point: the C_MAX_BEATS-th beat always closes the packet.
    assign force_last = granted && (beat_cnt_reg == LAST_BEAT);
    assign arb_tlast  = granted & (src_tlast[sel] | force_last);
    assign beat       = arb_tvalid & arb_ready;
    assign end_beat   = beat & arb_tlast;

    assign s00_axis_tready = (state_reg == ST_GRANT0) & arb_ready;
    assign s01_axis_tready = (state_reg == ST_GRANT1) & arb_ready;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (src_tvalid[0] && src_tvalid[1])
                    state_next = last_served_reg ? ST_GRANT0 : ST_GRANT1;
                else if (src_tvalid[0])
                    state_next = ST_GRANT0;
                else if (src_tvalid[1])
                    state_next = ST_GRANT1;
            end
            // On the end beat, hand straight over to a waiting peer so there
            // is no idle cycle between packets of different sources.
            ST_GRANT0: begin
                if (end_beat)
                    state_next = src_tvalid[1] ? ST_GRANT1 : ST_IDLE;
            end
            ST_GRANT1: begin
                if (end_beat)
                    state_next = src_tvalid[0] ? ST_GRANT0 : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_reg       <= ST_IDLE;
            last_served_reg <= 1'b1;
            beat_cnt_reg    <= '0;
            overrun_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (end_beat) begin
                last_served_reg <= sel;
                beat_cnt_reg    <= '0;
            end else if (beat) begin
                beat_cnt_reg    <= beat_cnt_reg + 1'b1;
            end
            // Clear has priority over a coincident truncation.
            if (stat_clear)
                overrun_reg <= 1'b0;
            else if (end_beat && force_last && !src_tlast[sel])
                overrun_reg <= 1'b1;
        end
    end

    // Per-source packet counters; clear wins over a coincident increment.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pkt_cnt
            always_ff @(posedge axis_aclk or posedge axis_areset) begin
                if (axis_areset)
                    pkt_cnt_reg[gi] <= '0;
                else if (stat_clear)
                    pkt_cnt_reg[gi] <= '0;
                else if (end_beat && (sel == 1'(gi)))
                    pkt_cnt_reg[gi] <= pkt_cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign pkt_cnt0 = pkt_cnt_reg[0];
    assign pkt_cnt1 = pkt_cnt_reg[1];
    assign overrun  = overrun_reg;

    // --------------------------------------------------------- output stage
`ifdef AXIS_ARB_OUT_REG_EN
    // Two-entry skid buffer: head drives m00, tail catches the beat accepted
    // in the cycle the head stalls. Upstream ready is simply "tail empty".
    logic [DW-1:0] head_tdata_reg, tail_tdata_reg;
    logic [SW-1:0] head_tstrb_reg, tail_tstrb_reg;
    logic          head_tlast_reg, tail_tlast_reg;
    logic          head_valid_reg, tail_valid_reg;
    logic          pop;

    assign arb_ready = ~tail_valid_reg;
    assign pop       = head_valid_reg & m00_axis_tready;

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            head_tdata_reg <= '0;
            head_tstrb_reg <= '0;
            head_tlast_reg <= 1'b0;
            head_valid_reg <= 1'b0;
            tail_tdata_reg <= '0;
            tail_tstrb_reg <= '0;
            tail_tlast_reg <= 1'b0;
            tail_valid_reg <= 1'b0;
        end else if (!head_valid_reg || pop) begin
            if (tail_valid_reg) begin
                head_tdata_reg <= tail_tdata_reg;
                head_tstrb_reg <= tail_tstrb_reg;
                head_tlast_reg <= tail_tlast_reg;
                head_valid_reg <= 1'b1;
                tail_valid_reg <= 1'b0;
            end else begin
                head_tdata_reg <= arb_tdata;
                head_tstrb_reg <= arb_tstrb;
                head_tlast_reg <= arb_tlast & beat;
                head_valid_reg <= beat;
            end
        end else if (beat) begin
            tail_tdata_reg <= arb_tdata;
            tail_tstrb_reg <= arb_tstrb;
            tail_tlast_reg <= arb_tlast;
            tail_valid_reg <= 1'b1;
        end
    end

    assign m00_axis_tdata  = head_tdata_reg;
    assign m00_axis_tstrb  = head_tstrb_reg;
    assign m00_axis_tlast  = head_tlast_reg;
    assign m00_axis_tvalid = head_valid_reg;
`else
    assign arb_ready       = m00_axis_tready;
    assign m00_axis_tdata  = arb_tdata;
    assign m00_axis_tstrb  = arb_tstrb;
    assign m00_axis_tlast  = arb_tlast;
    assign m00_axis_tvalid = arb_tvalid;
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for axis_rr_packet_arbiter. Instance dut_a uses default
// parameters, dut_b uses C_MAX_BEATS=4 for truncation. Both share inputs; each
// scenario observes one of them. Sources are queue-driven AXIS masters.
// -----------------------------------------------------------------------------
module tb_axis_rr_packet_arbiter;

`ifdef AXIS_ARB_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s0_tdata = '0, s1_tdata = '0;
    logic [3:0]  s0_tstrb = '0, s1_tstrb = '0;
    logic        s0_tlast = 1'b0, s0_tvalid = 1'b0;
    logic        s1_tlast = 1'b0, s1_tvalid = 1'b0;
    logic        m_ready = 1'b1;
    logic        stat_clear = 1'b0;

    logic        s0_tready_a, s1_tready_a, s0_tready_b, s1_tready_b;
    logic [31:0] m_tdata_a, m_tdata_b;
    logic [3:0]  m_tstrb_a, m_tstrb_b;
    logic        m_tlast_a, m_tlast_b, m_tvalid_a, m_tvalid_b;
    logic [15:0] pkt_cnt0_a, pkt_cnt1_a, pkt_cnt0_b, pkt_cnt1_b;
    logic        overrun_a, overrun_b;

    axis_rr_packet_arbiter dut_a (
        .axis_aclk(clk), .axis_areset(rst),
        .s00_axis_tdata(s0_tdata), .s00_axis_tstrb(s0_tstrb), .s00_axis_tlast(s0_tlast),
        .s00_axis_tvalid(s0_tvalid), .s00_axis_tready(s0_tready_a),
        .s01_axis_tdata(s1_tdata), .s01_axis_tstrb(s1_tstrb), .s01_axis_tlast(s1_tlast),
        .s01_axis_tvalid(s1_tvalid), .s01_axis_tready(s1_tready_a),
        .m00_axis_tdata(m_tdata_a), .m00_axis_tstrb(m_tstrb_a), .m00_axis_tlast(m_tlast_a),
        .m00_axis_tvalid(m_tvalid_a), .m00_axis_tready(m_ready),
        .stat_clear(stat_clear), .pkt_cnt0(pkt_cnt0_a), .pkt_cnt1(pkt_cnt1_a),
        .overrun(overrun_a)
    );

    axis_rr_packet_arbiter #(.C_MAX_BEATS(4)) dut_b (
        .axis_aclk(clk), .axis_areset(rst),
        .s00_axis_tdata(s0_tdata), .s00_axis_tstrb(s0_tstrb), .s00_axis_tlast(s0_tlast),
        .s00_axis_tvalid(s0_tvalid), .s00_axis_tready(s0_tready_b),
        .s01_axis_tdata(s1_tdata), .s01_axis_tstrb(s1_tstrb), .s01_axis_tlast(s1_tlast),
        .s01_axis_tvalid(s1_tvalid), .s01_axis_tready(s1_tready_b),
        .m00_axis_tdata(m_tdata_b), .m00_axis_tstrb(m_tstrb_b), .m00_axis_tlast(m_tlast_b),
        .m00_axis_tvalid(m_tvalid_b), .m00_axis_tready(m_ready),
        .stat_clear(stat_clear), .pkt_cnt0(pkt_cnt0_b), .pkt_cnt1(pkt_cnt1_b),
        .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic use_b = 1'b0;
    logic toggle = 1'b0;
    logic arm_clr = 1'b0;
    logic force_clr = 1'b0;
    logic s0_ready_seen = 1'b0;

    logic [32:0] q0 [$];        // {tlast, tdata}
    logic [32:0] q1 [$];
    logic [36:0] out_q [$];     // {tstrb, tlast, tdata}
    int          out_cyc [$];

    // Expected m00 entry; sources drive tstrb = tdata[3:0].
    function automatic logic [36:0] ent(input logic l, input logic [31:0] d);
        return {d[3:0], l, d};
    endfunction

    // One clock: sample handshakes at negedge, advance sources after posedge.
    task automatic step();
        logic acc0, acc1, mv, ml, r0;
        logic [31:0] md;
        logic [3:0]  ms;
        @(negedge clk);
        r0   = use_b ? s0_tready_b : s0_tready_a;
        acc0 = s0_tvalid && r0;
        acc1 = s1_tvalid && (use_b ? s1_tready_b : s1_tready_a);
        mv   = use_b ? m_tvalid_b : m_tvalid_a;
        ml   = use_b ? m_tlast_b  : m_tlast_a;
        md   = use_b ? m_tdata_b  : m_tdata_a;
        ms   = use_b ? m_tstrb_b  : m_tstrb_a;
        if (mv && m_ready) begin
            out_q.push_back({ms, ml, md});
            out_cyc.push_back(cyc);
        end
        if (r0) s0_ready_seen = 1'b1;
        cyc++;
        @(posedge clk);
        #1;
        if (acc0) q0.delete(0);
        if (acc1) q1.delete(0);
        if (q0.size() > 0) begin
            s0_tvalid = 1'b1; s0_tdata = q0[0][31:0]; s0_tlast = q0[0][32];
        end else begin
            s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
        end
        if (q1.size() > 0) begin
            s1_tvalid = 1'b1; s1_tdata = q1[0][31:0]; s1_tlast = q1[0][32];
        end else begin
            s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
        end
        s0_tstrb   = s0_tdata[3:0];
        s1_tstrb   = s1_tdata[3:0];
        stat_clear = force_clr | (arm_clr & s1_tvalid & s1_tlast);
        m_ready    = toggle ? ~m_ready : 1'b1;
    endtask

    task automatic run_until(input string name, input int n, input int budget);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (out_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout beats %0d required %0d", name, out_q.size(), n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete(); q1.delete(); out_q.delete(); out_cyc.delete();
        s0_tvalid = 0; s0_tdata = '0; s0_tstrb = '0; s0_tlast = 0;
        s1_tvalid = 0; s1_tdata = '0; s1_tstrb = '0; s1_tlast = 0;
        m_ready = 1'b1; toggle = 0; arm_clr = 0; force_clr = 0; stat_clear = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        s0_ready_seen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s0_tready_a !== 1'b0) begin errors++; $display("FAIL reset_s0_tready got %b expected 0", s0_tready_a); end
        checks++; if (s1_tready_a !== 1'b0) begin errors++; $display("FAIL reset_s1_tready got %b expected 0", s1_tready_a); end
        checks++; if (m_tvalid_a !== 1'b0)  begin errors++; $display("FAIL reset_tvalid got %b expected 0", m_tvalid_a); end
        checks++; if (m_tlast_a !== 1'b0)   begin errors++; $display("FAIL reset_tlast got %b expected 0", m_tlast_a); end
        checks++; if (pkt_cnt0_a !== 16'd0 || pkt_cnt1_a !== 16'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d expected 0/0", pkt_cnt0_a, pkt_cnt1_a);
        end
        checks++; if (overrun_a !== 1'b0 || overrun_b !== 1'b0) begin
            errors++; $display("FAIL reset_overrun got %b/%b expected 0/0", overrun_a, overrun_b);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [36:0] e [4];
        int start;
        do_reset(); use_b = 1'b0;
        for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 32'(i)});
        for (int i = 0; i < 4; i++) e[i] = ent(i == 3, 32'(i));
        step(); start = cyc;
        run_until("t1", 4, 20);
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== e[i]) begin errors++; $display("FAIL t1_beat%0d got %h expected %h", i, out_q[i], e[i]); end
        end
        if (out_q.size() >= 4) begin
            checks++;
            if (out_cyc[0] !== start + 1 + LAT) begin
                errors++; $display("FAIL t1_latency got cycle %0d expected %0d", out_cyc[0], start + 1 + LAT);
            end
            checks++;
            if (out_cyc[3] - out_cyc[0] !== 3) begin
                errors++; $display("FAIL t1_span got %0d expected 3", out_cyc[3] - out_cyc[0]);
            end
        end
        checks++;
        if (pkt_cnt0_a !== 16'd1 || pkt_cnt1_a !== 16'd0) begin
            errors++; $display("FAIL t1_cnt got %0d/%0d expected 1/0", pkt_cnt0_a, pkt_cnt1_a);
        end
        $display("test_single: %0d beats, first at cycle %0d", out_q.size(), out_q.size() > 0 ? out_cyc[0] : -1);
    endtask

    task automatic test_back_to_back();
        logic [36:0] e [12];
        do_reset(); use_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            q0.push_back({(i % 3 == 2), 32'h10 + 32'(i)});
            q1.push_back({(i % 3 == 2), 32'h20 + 32'(i)});
        end
        for (int i = 0; i < 3; i++) begin
            e[i]     = ent(i == 2, 32'h10 + 32'(i));
            e[i + 3] = ent(i == 2, 32'h20 + 32'(i));
            e[i + 6] = ent(i == 2, 32'h13 + 32'(i));
            e[i + 9] = ent(i == 2, 32'h23 + 32'(i));
        end
        step();
        run_until("t2", 12, 40);
        for (int i = 0; i < 12 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== e[i]) begin errors++; $display("FAIL t2_beat%0d got %h expected %h", i, out_q[i], e[i]); end
        end
        if (out_q.size() >= 12) begin
            checks++;
            if (out_cyc[11] - out_cyc[0] !== 11) begin
                errors++; $display("FAIL t2_gap span got %0d expected 11", out_cyc[11] - out_cyc[0]);
            end
        end
        checks++;
        if (pkt_cnt0_a !== 16'd2 || pkt_cnt1_a !== 16'd2) begin
            errors++; $display("FAIL t2_cnt got %0d/%0d expected 2/2", pkt_cnt0_a, pkt_cnt1_a);
        end
        $display("test_back_to_back: %0d beats", out_q.size());
    endtask

    task automatic test_backpressure();
        logic [36:0] e [8];
        do_reset(); use_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q1.push_back({(i == 7), 32'h30 + 32'(i)});
            e[i] = ent(i == 7, 32'h30 + 32'(i));
        end
        toggle = 1'b1;
        step();
        run_until("t3", 8, 60);
        toggle = 1'b0;
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== e[i]) begin errors++; $display("FAIL t3_beat%0d got %h expected %h", i, out_q[i], e[i]); end
        end
        if (out_q.size() >= 8) begin
            checks++;
            if (out_cyc[7] - out_cyc[0] !== 14) begin
                errors++; $display("FAIL t3_span got %0d expected 14", out_cyc[7] - out_cyc[0]);
            end
        end
        checks++;
        if (s0_ready_seen !== 1'b0) begin errors++; $display("FAIL t3_s0_tready got 1 expected 0"); end
        checks++;
        if (pkt_cnt1_a !== 16'd1) begin errors++; $display("FAIL t3_cnt1 got %0d expected 1", pkt_cnt1_a); end
        $display("test_backpressure: %0d beats", out_q.size());
    endtask

    task automatic test_overrun();
        logic [36:0] e [6];
        do_reset(); use_b = 1'b1;
        for (int i = 0; i < 6; i++) q0.push_back({(i == 5), 32'h40 + 32'(i)});
        for (int i = 0; i < 6; i++) e[i] = ent(i == 3 || i == 5, 32'h40 + 32'(i));
        step();
        run_until("t4", 6, 40);
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== e[i]) begin errors++; $display("FAIL t4_beat%0d got %h expected %h", i, out_q[i], e[i]); end
        end
        checks++;
        if (overrun_b !== 1'b1) begin errors++; $display("FAIL t4_overrun got %b expected 1", overrun_b); end
        checks++;
        if (pkt_cnt0_b !== 16'd2) begin errors++; $display("FAIL t4_cnt0 got %0d expected 2", pkt_cnt0_b); end
        force_clr = 1'b1; step(); force_clr = 1'b0; step();
        checks++;
        if (overrun_b !== 1'b0 || pkt_cnt0_b !== 16'd0) begin
            errors++; $display("FAIL t4_clear got overrun %b cnt %0d expected 0/0", overrun_b, pkt_cnt0_b);
        end
        use_b = 1'b0;
        $display("test_overrun: %0d beats", out_q.size());
    endtask

    task automatic test_clear_and_reset();
        do_reset(); use_b = 1'b0;
        q1.push_back({1'b0, 32'h50}); q1.push_back({1'b1, 32'h51});
        step();
        run_until("t5a", 2, 20);
        checks++;
        if (pkt_cnt1_a !== 16'd1) begin errors++; $display("FAIL t5_cnt1_pre got %0d expected 1", pkt_cnt1_a); end
        arm_clr = 1'b1;
        q1.push_back({1'b0, 32'h52}); q1.push_back({1'b1, 32'h53});
        step();
        run_until("t5b", 4, 20);
        arm_clr = 1'b0;
        if (out_q.size() >= 4) begin
            checks++;
            if (out_q[3] !== ent(1'b1, 32'h53)) begin errors++; $display("FAIL t5_lastbeat got %h expected %h", out_q[3], ent(1'b1, 32'h53)); end
        end
        checks++;
        if (pkt_cnt1_a !== 16'd0) begin errors++; $display("FAIL t5_clear_wins got %0d expected 0", pkt_cnt1_a); end

        // Serve s00 once so last_served points at s00, then reset inside an s01 packet.
        do_reset(); use_b = 1'b0;
        q0.push_back({1'b1, 32'h60});
        for (int i = 0; i < 4; i++) q1.push_back({(i == 3), 32'h70 + 32'(i)});
        step();
        run_until("t5c", 2, 20);
        rst = 1'b1;
        #1;
        checks++; if (s0_tready_a !== 1'b0 || s1_tready_a !== 1'b0) begin
            errors++; $display("FAIL t5_rst_tready got %b/%b expected 0/0", s0_tready_a, s1_tready_a);
        end
        checks++; if (m_tvalid_a !== 1'b0 || m_tlast_a !== 1'b0) begin
            errors++; $display("FAIL t5_rst_m00 got valid %b last %b expected 0/0", m_tvalid_a, m_tlast_a);
        end
        checks++; if (pkt_cnt0_a !== 16'd0) begin errors++; $display("FAIL t5_rst_cnt0 got %0d expected 0", pkt_cnt0_a); end
        do_reset(); use_b = 1'b0;
        q0.push_back({1'b1, 32'h90});
        q1.push_back({1'b1, 32'h80});
        step();
        run_until("t5d", 2, 20);
        if (out_q.size() >= 2) begin
            checks++;
            if (out_q[0] !== ent(1'b1, 32'h90)) begin errors++; $display("FAIL t5_first_after_rst got %h expected %h", out_q[0], ent(1'b1, 32'h90)); end
            checks++;
            if (out_q[1] !== ent(1'b1, 32'h80)) begin errors++; $display("FAIL t5_second_after_rst got %h expected %h", out_q[1], ent(1'b1, 32'h80)); end
        end
        $display("test_clear_and_reset done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overrun();
        test_clear_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
